// File: rtl/eps_greedy_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eps_greedy_ctrl                                              |
// | Description : Epsilon-greedy action selector. Scans the Q-values of one    |
// |               state, tracks the signed argmax, and picks either the greedy |
// |               action or an LFSR-derived random action.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eps_greedy_ctrl #(
  parameter int          N_ACT     = 15,
  parameter int          ACT_W     = 4,
  parameter int          DATA_W    = 16,
  parameter int          STATE_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [STATE_W-1:0]        state_in,
  input  logic [7:0]                epsilon,
  output logic                      q_rd_en,
  output logic [STATE_W-1:0]        q_rd_state,
  output logic [ACT_W-1:0]          q_rd_act,
  input  logic signed [DATA_W-1:0]  q_rd_data,
  output logic                      busy,
  output logic                      done,
  output logic [ACT_W-1:0]          action_out,
  output logic signed [DATA_W-1:0]  q_max_out,
  output logic                      explore_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ACT_W-1:0] LAST_ACT  = ACT_W'(N_ACT - 1);
  localparam logic [ACT_W:0]   N_ACT_EXT = (ACT_W+1)'(N_ACT);

  state_t                     state_q, state_d;
  logic [15:0]                lfsr_q, lfsr_d;
  logic [STATE_W-1:0]         st_q;
  logic [ACT_W-1:0]           act_cnt_q;
  logic                       rd_v_q;
  logic [ACT_W-1:0]           rd_idx_q;
  logic signed [DATA_W-1:0]   max_q;
  logic [ACT_W-1:0]           arg_q;
  logic                       expl_q;
  logic [ACT_W-1:0]           rnd_q;
  logic [ACT_W-1:0]           action_q;
  logic signed [DATA_W-1:0]   qmax_q;
  logic                       explore_q;

  logic                       w_accept;
  logic                       w_snap_explore;
  logic [ACT_W-1:0]           w_rnd_raw;
  logic [ACT_W:0]             w_rnd_sub;
  logic [ACT_W-1:0]           w_rnd;
  logic                       w_take;
  logic signed [DATA_W-1:0]   w_max_nxt;
  logic [ACT_W-1:0]           w_arg_nxt;

  // Fibonacci LFSR step (taps 16,14,13,11) plus the exploration snapshot and
  // the compare-pipeline next values.
  always_comb begin
    lfsr_d         = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    w_accept       = (state_q == S_IDLE) && start;
    w_snap_explore = (lfsr_q[7:0] < epsilon);
    w_rnd_raw      = lfsr_q[8 +: ACT_W];
    w_rnd_sub      = {1'b0, w_rnd_raw} - N_ACT_EXT;
    w_rnd          = ({1'b0, w_rnd_raw} >= N_ACT_EXT) ? w_rnd_sub[ACT_W-1:0] : w_rnd_raw;
    // First sample loads unconditionally; later ones only if strictly greater,
    // which keeps the lowest index on ties.
    w_take         = rd_v_q && ((rd_idx_q == '0) || (q_rd_data > max_q));
    w_max_nxt      = w_take ? q_rd_data : max_q;
    w_arg_nxt      = w_take ? rd_idx_q  : arg_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and strobes.
  always_comb begin
    state_d = state_q;
    q_rd_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SCAN;
      end
      S_SCAN: begin
        q_rd_en = 1'b1;
        busy    = 1'b1;
        if (act_cnt_q == LAST_ACT) state_d = S_LAST;
      end
      S_LAST: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: LFSR, request latch, read counter, compare pipeline and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q    <= LFSR_SEED;
      st_q      <= '0;
      act_cnt_q <= '0;
      rd_v_q    <= 1'b0;
      rd_idx_q  <= '0;
      max_q     <= '0;
      arg_q     <= '0;
      expl_q    <= 1'b0;
      rnd_q     <= '0;
      action_q  <= '0;
      qmax_q    <= '0;
      explore_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      rd_v_q   <= q_rd_en;
      rd_idx_q <= act_cnt_q;
      max_q    <= w_max_nxt;
      arg_q    <= w_arg_nxt;
      if (w_accept) begin
        st_q      <= state_in;
        expl_q    <= w_snap_explore;
        rnd_q     <= w_rnd;
        act_cnt_q <= '0;
      end else if (state_q == S_SCAN) begin
        act_cnt_q <= act_cnt_q + 1'b1;
      end
      // The final sample is folded in at the same edge that publishes results.
      if (state_q == S_LAST) begin
        qmax_q    <= w_max_nxt;
        action_q  <= expl_q ? rnd_q : w_arg_nxt;
        explore_q <= expl_q;
      end
    end
  end

  assign q_rd_state  = st_q;
  assign q_rd_act    = act_cnt_q;
  assign action_out  = action_q;
  assign q_max_out   = qmax_q;
  assign explore_out = explore_q;

endmodule
`default_nettype wire

// File: tb/tb_eps_greedy_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_eps_greedy_ctrl                                           |
// | Description : Scoreboard bench for eps_greedy_ctrl with a reference model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_eps_greedy_ctrl;

  localparam int          N_ACT = 15;
  localparam logic [15:0] SEED  = 16'hACE1;

  typedef struct packed {
    logic [3:0]         act;
    logic signed [15:0] qmax;
    logic               expl;
  } res_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         state_in = '0;
  logic [7:0]         epsilon = '0;
  logic               q_rd_en;
  logic [7:0]         q_rd_state;
  logic [3:0]         q_rd_act;
  logic signed [15:0] q_rd_data = '0;
  logic               busy;
  logic               done;
  logic [3:0]         action_out;
  logic signed [15:0] q_max_out;
  logic               explore_out;

  int tests = 0;
  int fails = 0;

  logic signed [15:0] qtab [0:255][0:N_ACT-1];

  res_t        exp_q[$];
  res_t        hold = '0;
  int          ph = -1;
  logic [15:0] m_lfsr = SEED;
  logic [7:0]  m_state = '0;

  eps_greedy_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .state_in   (state_in),
    .epsilon    (epsilon),
    .q_rd_en    (q_rd_en),
    .q_rd_state (q_rd_state),
    .q_rd_act   (q_rd_act),
    .q_rd_data  (q_rd_data),
    .busy       (busy),
    .done       (done),
    .action_out (action_out),
    .q_max_out  (q_max_out),
    .explore_out(explore_out)
  );

  always #5 clk = ~clk;

  // Q-table memory with one cycle of read latency.
  always @(posedge clk) begin
    if (q_rd_en) q_rd_data <= (q_rd_act < 4'(N_ACT)) ? qtab[q_rd_state][q_rd_act] : '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  // Expected result from the rules: greedy = first index of the signed max;
  // explore when the low LFSR byte is below epsilon; random = bits 11:8 mod N_ACT.
  function automatic res_t predict(input logic [7:0] s, input logic [7:0] e, input logic [15:0] snap);
    res_t r;
    int best_i = 0;
    int rnd;
    for (int i = 1; i < N_ACT; i++) begin
      if (qtab[s][i] > qtab[s][best_i]) best_i = i;
    end
    rnd    = int'(snap[11:8]) % N_ACT;
    r.expl = (snap[7:0] < e);
    r.qmax = qtab[s][best_i];
    r.act  = r.expl ? 4'(rnd) : 4'(best_i);
    return r;
  endfunction

  // Reference model: cycles since acceptance (ph) and the LFSR sequence.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr = SEED;
      ph     = -1;
      exp_q.delete();
    end else begin
      if (ph == -1) begin
        if (start) begin
          exp_q.push_back(predict(state_in, epsilon, m_lfsr));
          m_state = state_in;
          ph      = 0;
        end
      end else if (ph == 16) begin
        ph = -1;
      end else begin
        ph++;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // Monitor: strobes every cycle, results popped from the scoreboard on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = '0;
    end else begin
      chk("q_rd_en", 32'(q_rd_en), 32'(ph >= 0 && ph <= 14));
      if (ph >= 0 && ph <= 14) begin
        chk("q_rd_act", 32'(q_rd_act), 32'(ph));
        chk("q_rd_state", 32'(q_rd_state), 32'(m_state));
      end
      chk("busy", 32'(busy), 32'(ph >= 0));
      chk("done", 32'(done), 32'(ph == 16));
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: got done=1 expected no result pending at %0t", $time);
        end else begin
          hold = exp_q.pop_front();
          chk("action_range", 32'(action_out < 4'(N_ACT)), 32'd1);
        end
      end
      chk("action_out", 32'(action_out), 32'(hold.act));
      chk("q_max_out", 32'(q_max_out), 32'(hold.qmax));
      chk("explore_out", 32'(explore_out), 32'(hold.expl));
    end
  end

  task automatic issue(input logic [7:0] s, input logic [7:0] e);
    @(negedge clk);
    start    = 1'b1;
    state_in = s;
    epsilon  = e;
    @(negedge clk);
    start    = 1'b0;
    state_in = 8'($urandom);
    epsilon  = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles at %0t", $time);
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [7:0] s, input logic [7:0] e);
    issue(s, e);
    wait_done();
  endtask

  initial begin
    for (int s = 0; s < 256; s++)
      for (int a = 0; a < N_ACT; a++)
        qtab[s][a] = 16'($urandom);
    for (int a = 0; a < N_ACT; a++) begin
      qtab[3][a] = '0;
      qtab[4][a] = -16'sd32768;
      qtab[5][a] = -16'sd32768;
    end
    qtab[3][0] = 16'sd1; qtab[3][1] = 16'sd2; qtab[3][2] = 16'sd3; qtab[3][3] = 16'sd4;
    qtab[4][0] = -16'sd5; qtab[4][1] = -16'sd3; qtab[4][2] = -16'sd9; qtab[4][3] = -16'sd3;
    qtab[5][14] = 16'sd7;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_q_rd_en", 32'(q_rd_en), 32'd0);
    chk("rst_action", 32'(action_out), 32'd0);
    #2 rst_n = 1'b1;

    // Directed rows: ascending, negative with tie, max in last slot.
    run(8'd3, 8'd0);
    chk("row3_action", 32'(action_out), 32'd3);
    chk("row3_qmax", 32'(q_max_out), 32'(16'sd4));
    run(8'd4, 8'd0);
    chk("row4_action", 32'(action_out), 32'd1);
    chk("row4_qmax", 32'(q_max_out), 32'(-16'sd3));
    run(8'd5, 8'd0);
    chk("row5_action", 32'(action_out), 32'd14);
    chk("row5_qmax", 32'(q_max_out), 32'(16'sd7));

    // start pulses while busy are dropped.
    issue(8'd3, 8'd0);
    repeat (2) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // start held high: back-to-back requests.
    @(negedge clk);
    start = 1'b1;
    repeat (80) begin
      state_in = 8'($urandom_range(0, 7));
      epsilon  = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Asynchronous reset in the sixth scan cycle.
    issue(8'd3, 8'd0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_q_rd_en", 32'(q_rd_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_action", 32'(action_out), 32'd0);
    chk("abort_qmax", 32'(q_max_out), 32'd0);
    chk("abort_explore", 32'(explore_out), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(8'd5, 8'd0);
    chk("post_rst_action", 32'(action_out), 32'd14);

    // Heavy exploration on a fixed random row.
    repeat (64) run(8'd6, 8'd255);

    // Random requests.
    repeat (30) run(8'($urandom), 8'($urandom));

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
